// File: rtl/serial_sub_ctrl_pkg.sv
//-----------------------------------------------------------------------------
// serial_sub_pkg
// Shared definitions for the bit-serial subtractor controller:
//   - DEFAULT_WIDTH : default operand/result width in bits
//   - state_t       : controller FSM states (IDLE, SHIFT, DONE)
//-----------------------------------------------------------------------------
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : serial_sub_pkg

// File: rtl/serial_sub_ctrl_if.sv
//-----------------------------------------------------------------------------
// serial_sub_ctrl_if
// Request/result bundle of the bit-serial subtractor.
//   start : request, sampled only while the controller is idle
//   a, b  : minuend / subtrahend, sampled on the accepting edge
//   busy  : high while bits are being processed
//   done  : one-cycle pulse, diff/bo are final
//   diff  : (a - b) mod 2^WIDTH
//   bo    : final borrow, 1 iff a < b (unsigned)
// Modports: master drives the request, slave is the subtractor.
//-----------------------------------------------------------------------------
import serial_sub_pkg::*;

interface serial_sub_ctrl_if #(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bo;

    modport master (
        output start, a, b,
        input  busy, done, diff, bo
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, bo
    );
endinterface : serial_sub_ctrl_if

// File: rtl/serial_sub_ctrl_full_sub_bit.sv
//-----------------------------------------------------------------------------
// half_sub / full_sub_bit
// Combinational one-bit subtractor cells.
//   half_sub     : x, y        -> d = x ^ y, bout = ~x & y
//   full_sub_bit : a, b, bin   -> d = a ^ b ^ bin,
//                                 bout = (~a & b) | (~(a ^ b) & bin)
// The full cell is two half cells in series (a-b, then minus bin) with
// the two partial borrows OR-ed; they can never both be 1.
//-----------------------------------------------------------------------------
module half_sub (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bout
);
    assign d    = x ^ y;
    assign bout = ~x & y;
endmodule : half_sub

module full_sub_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic w_d1;
    logic w_b1;
    logic w_b2;

    half_sub u_hs_ab (
        .x    (a),
        .y    (b),
        .d    (w_d1),
        .bout (w_b1)
    );

    half_sub u_hs_bin (
        .x    (w_d1),
        .y    (bin),
        .d    (d),
        .bout (w_b2)
    );

    assign bout = w_b1 | w_b2;
endmodule : full_sub_bit

// File: rtl/serial_sub_ctrl.sv
//-----------------------------------------------------------------------------
// serial_sub_ctrl
// Bit-serial WIDTH-bit unsigned subtractor. A start accepted in IDLE
// latches a and b; the next WIDTH edges feed their LSBs through a single
// full_sub_bit cell, LSB first, with the borrow held in a flop. The
// difference is shifted in from the MSB side so that after WIDTH shifts
// bit 0 lands in diff[0]. A one-cycle done pulse follows.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : serial_sub_ctrl_if.slave (start, a, b, busy, done, diff, bo)
// All outputs are driven directly by flops.
//-----------------------------------------------------------------------------
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_sub_ctrl_if.slave   bus
);
    // WIDTH >= 2 keeps CW >= 1; the counter only needs to reach WIDTH-1.
    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic              w_accept;
    logic              w_shift;
    logic              w_last;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_bin;
    logic [CW-1:0]     r_cnt;
    logic [WIDTH-1:0]  r_diff;
    logic              r_bo;
    logic              r_busy;
    logic              r_done;

    logic              w_d;
    logic              w_bout;

    full_sub_bit u_full_sub_bit (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_bin),
        .d    (w_d),
        .bout (w_bout)
    );

    //-------------------------------------------------------------------------
    // FSM state register
    //-------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    //-------------------------------------------------------------------------
    // FSM next-state and datapath strobes
    //-------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_shift      = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                w_shift = 1'b1;
                if (r_cnt == LAST_BIT) begin
                    w_last       = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    //-------------------------------------------------------------------------
    // Status flags registered from the next state so busy/done are
    // clean flop outputs aligned with the state they describe.
    //-------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_next == SHIFT);
            r_done <= (w_state_next == DONE);
        end
    end

    //-------------------------------------------------------------------------
    // Operand shift registers, borrow flop, bit counter and results
    //-------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_bin  <= 1'b0;
            r_cnt  <= '0;
            r_diff <= '0;
            r_bo   <= 1'b0;
        end else if (w_accept) begin
            r_a    <= bus.a;
            r_b    <= bus.b;
            r_bin  <= 1'b0;
            r_cnt  <= '0;
            r_diff <= '0;
            r_bo   <= 1'b0;
        end else if (w_shift) begin
            r_a    <= r_a >> 1;
            r_b    <= r_b >> 1;
            r_bin  <= w_bout;
            r_cnt  <= r_cnt + CW'(1);
            r_diff <= {w_d, r_diff[WIDTH-1:1]};
            if (w_last) begin
                r_bo <= w_bout;
            end
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.diff = r_diff;
    assign bus.bo   = r_bo;

endmodule : serial_sub_ctrl

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial multi-bit subtractor controller. It latches two WIDTH-bit unsigned operands on a start request and sequences a single one-bit full-subtractor cell over WIDTH cycles, LSB first, carrying the borrow in a flip-flop. It returns the difference and the final borrow with a one-cycle done pulse. It is the sequencing layer that turns the one-bit subtractor cell into a usable WIDTH-bit subtraction unit for area-constrained datapaths.

## Interface
- WIDTH, default 8: operand/result width in bits; legal range ≥ 2.
- clk  input  1  the only clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled on the edge that accepts start.
- b  input  WIDTH  subtrahend; sampled on the edge that accepts start.
- busy  output  1  high while state = SHIFT.
- done  output  1  one-cycle pulse; diff and bo are final.
- diff  output  WIDTH  (a − b) mod 2^WIDTH; registered.
- bo  output  1  final borrow; 1 iff a < b (unsigned); registered.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - latch a and b into shift registers.
  - clear the borrow flop, clear diff, clear bo, clear the bit counter.
  - go to SHIFT.
- IDLE, start=0: hold all outputs.
- SHIFT, each cycle:
  - apply the full subtractor to the current LSBs: d = a0 ^ b0 ^ bin; bout = (~a0 & b0) | (~(a0 ^ b0) & bin).
  - shift d into the MSB of diff (diff shifts right).
  - shift the a and b registers right by 1.
  - borrow flop ← bout; counter ← counter + 1.
- SHIFT exit: on the edge processing bit WIDTH−1 (counter = WIDTH−1), load bo ← bout and go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- diff and bo hold their final values through DONE and IDLE until the next accepted start.
- start while in SHIFT or DONE: ignored. No queuing; a and b changes are ignored.
- Counter width: $clog2(WIDTH). It must not wrap before the exit compare.

## Timing
- Reset (async assert, any state):
  - state = IDLE; busy=0, done=0, diff=0, bo=0.
  - borrow flop, counter and operand registers = 0.
- Reset mid-operation: aborts the operation; no done pulse; the next start after deassertion behaves normally.
- Edge E0: accepts start. busy is high from E0 to E_WIDTH.
- Edges E1..E_WIDTH: process bits 0..WIDTH−1.
- done is high between E_WIDTH and E_WIDTH+1; busy is 0 in that cycle.
- Latency: done is asserted WIDTH cycles after the accepting edge.
- Throughput: one subtraction per WIDTH+2 cycles. The earliest next start is accepted at E_WIDTH+2 (back in IDLE).
- All outputs come straight from flops; no combinational path from inputs to outputs.

## Structure
- Package serial_sub_pkg:
  - state enum (IDLE, SHIFT, DONE).
  - default WIDTH constant.
- Sub-module full_sub_bit:
  - combinational one-bit full subtractor (inputs a, b, bin; outputs d, bout).
  - built from two half-subtractor cells plus an OR of their borrows.
  - instantiated once in serial_sub_ctrl.
- Top contains the FSM, counter, operand shift registers, borrow flop and result registers.

## Test plan
All cases use WIDTH=8.
- a=0x5A, b=0x23, start pulse → busy for 8 cycles; done at E8; diff=0x37, bo=0.
- a=0x23, b=0x5A → diff=0xC9, bo=1.
- a=0x00, b=0x01 → diff=0xFF, bo=1 (borrow ripples all bits). Then a=0xFF, b=0xFF → diff=0x00, bo=0.
- Start held high continuously with operands changing every cycle:
  - only the IDLE-sampled operands are used.
  - one done per WIDTH+2 cycles.
  - the result matches the operands latched at each accept.
- Assert rst_n=0 at E4 of a 0x5A−0x23 operation → immediately diff=0, bo=0, busy=0, no done. After release, 0x10−0x01 gives diff=0x0F, bo=0.
- After a completed operation, idle for 5 cycles → diff and bo are held, done stays 0.
